// File: rtl/logic_unit_pkg.sv
// Shared definitions for the bitwise logic unit and its request arbiter.
package logic_unit_pkg;

  // Opcodes understood by the logic unit
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_NOT = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // Arbiter FSM: accept a request, run the unit, present the result
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/logic_unit.sv
// Purely combinational bitwise datapath: y = op(a, b), full WIDTH, no extension.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Select the bitwise function; NOT ignores b and complements all bits of a
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit between NUM_REQ requesters.
// One request is in flight at a time: accept (IDLE) -> compute (EXEC) -> hold result (RESP).
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              found_hi_s, found_lo_s, grant_found_s;
  logic [ID_W-1:0]   grant_hi_s, grant_lo_s, grant_s;
  logic [1:0]        grant_op_s;
  logic [WIDTH-1:0]  grant_a_s, grant_b_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [WIDTH-1:0]  lu_y_s;

  // Round-robin search: lowest valid index at or above rr_ptr wins, else lowest valid below it
  always_comb begin
    found_hi_s = 1'b0;
    found_lo_s = 1'b0;
    grant_hi_s = '0;
    grant_lo_s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (ID_W'(i) >= rr_ptr_q) begin
          found_hi_s = 1'b1;
          grant_hi_s = ID_W'(i);
        end else begin
          found_lo_s = 1'b1;
          grant_lo_s = ID_W'(i);
        end
      end else begin
        found_hi_s = found_hi_s;
      end
    end
    grant_found_s = found_hi_s | found_lo_s;
    grant_s       = found_hi_s ? grant_hi_s : grant_lo_s;
  end

  // Pick the granted requester's opcode and operands
  always_comb begin
    grant_op_s = '0;
    grant_a_s  = '0;
    grant_b_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_s) begin
        grant_op_s = req_op[2*i +: 2];
        grant_a_s  = req_a[WIDTH*i +: WIDTH];
        grant_b_s  = req_b[WIDTH*i +: WIDTH];
      end else begin
        grant_op_s = grant_op_s;
      end
    end
  end

  logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (lu_y_s)
  );

  // FSM next state, handshake and register updates
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    ready_s     = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          ready_s  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_s;
          op_d     = grant_op_s;
          a_d      = grant_a_s;
          b_d      = grant_b_s;
          id_d     = grant_s;
          rr_ptr_d = (grant_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_s + ID_W'(1);
          state_d  = ST_EXEC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = lu_y_s;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // req_ready is forced low while reset is asserted, even though state already reads IDLE
  always_comb begin
    if (rst) begin
      req_ready = '0;
    end else begin
      req_ready = ready_s;
    end
  end

  // State, operand and result registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      op_q        <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: vector table, directed corner cases,
// and a randomized run against a transaction-level reference model.
module tb_logic_unit_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_data;

  logic [1:0]   t_op [N];
  logic [W-1:0] t_a  [N];
  logic [W-1:0] t_b  [N];

  int n_pass  = 0;
  int n_total = 0;

  logic_unit_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2] = t_op[i];
      req_a[W*i +: W]  = t_a[i];
      req_b[W*i +: W]  = t_b[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: the opcode table
  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~a;
      default: return a ^ b;
    endcase
  endfunction

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    t_op[i] = op;
    t_a[i]  = a;
    t_b[i]  = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits (bounded) for a grant; returns its index or -1, leaves time just after the transfer edge
  task automatic wait_grant(output int g);
    g = -1;
    for (int c = 0; c < 20 && g < 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int         id;
    logic [1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
  } vec_t;

  vec_t vecs [5];

  typedef struct {
    int         id;
    logic [W-1:0] y;
    int         cyc;
  } txn_t;

  task automatic run_vector(input vec_t v);
    set_req(v.id, v.op, v.a, v.b);
    req_valid = N'(1) << v.id;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("vec_ready_id%0d", v.id), req_ready, N'(1) << v.id);
    @(posedge clk);
    #1;
    req_valid = '0;
    t_a[v.id] = W'($urandom);
    t_b[v.id] = W'($urandom);
    @(negedge clk);
    chk("vec_no_early_valid", rsp_valid, 1'b0);
    @(negedge clk);
    chk("vec_rsp_valid", rsp_valid, 1'b1);
    chk($sformatf("vec_data_op%0d", v.op), rsp_data, v.y);
    chk("vec_rsp_id", rsp_id, v.id);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_phase();
    txn_t q[$];
    int mptr;
    int cyc;
    int g;
    int granted;
    logic [N-1:0] exp_rdy;
    logic exp_v;
    do_reset();
    mptr = 0;
    cyc = 0;
    for (int it = 0; it < 900; it++) begin
      bit arrivals;
      arrivals = (it < 800);
      if (!arrivals && req_valid == '0 && q.size() == 0) break;
      @(negedge clk);
      cyc++;
      exp_rdy = '0;
      g = -1;
      if (q.size() == 0 && req_valid != '0) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
        end
        exp_rdy[g] = 1'b1;
      end
      chk("rand_req_ready", req_ready, exp_rdy);
      exp_v = (q.size() > 0) && (cyc >= q[0].cyc + 2);
      chk("rand_rsp_valid", rsp_valid, exp_v);
      if (exp_v && rsp_valid) begin
        chk("rand_rsp_data", rsp_data, q[0].y);
        chk("rand_rsp_id", rsp_id, q[0].id);
        if (rsp_ready) void'(q.pop_front());
      end
      granted = -1;
      if (g >= 0) begin
        q.push_back('{g, ref_op(t_op[g], t_a[g], t_b[g]), cyc});
        mptr = (g + 1) % N;
        granted = g;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (i == granted) begin
          req_valid[i] = arrivals && ($urandom_range(0, 1) == 0);
          set_req(i, 2'($urandom), W'($urandom), W'($urandom));
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) set_req(i, 2'($urandom), W'($urandom), W'($urandom));
        end else if (arrivals && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          set_req(i, 2'($urandom), W'($urandom), W'($urandom));
        end
      end
      rsp_ready = arrivals ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    chk("rand_drained", {31'd0, (q.size() == 0 && req_valid == '0)}, 32'd1);
  endtask

  initial begin
    int g;
    vecs[0] = '{2, 2'b00, 8'hF0, 8'h3C, 8'h30};
    vecs[1] = '{0, 2'b00, 8'hA5, 8'h0F, 8'h05};
    vecs[2] = '{1, 2'b01, 8'hA5, 8'h0F, 8'hAF};
    vecs[3] = '{3, 2'b10, 8'hA5, 8'h0F, 8'h5A};
    vecs[4] = '{2, 2'b11, 8'hA5, 8'h0F, 8'hAA};
    for (int i = 0; i < N; i++) set_req(i, 2'b00, 8'h00, 8'h00);

    // Reset state, with requests asserted to show req_ready stays low
    rst = 1'b1;
    req_valid = '1;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 4'b0000);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_data", rsp_data, 8'h00);
    chk("reset_rsp_id", rsp_id, 2'd0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b0;

    for (int v = 0; v < 5; v++) run_vector(vecs[v]);

    // Round robin with every requester valid
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 2'($urandom), W'($urandom), W'($urandom));
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      chk($sformatf("rr_grant_%0d", k), g, k % N);
    end
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: result and ids held while rsp_ready is low
    do_reset();
    set_req(1, 2'b11, 8'h3C, 8'hFF);
    req_valid = 4'b0010;
    wait_grant(g);
    chk("bp_grant", g, 1);
    req_valid = 4'b1101;
    @(negedge clk);
    chk("bp_exec_ready", req_ready, 4'b0000);
    @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_data", rsp_data, 8'hC3);
      chk("bp_hold_id", rsp_id, 2'd1);
      chk("bp_hold_ready", req_ready, 4'b0000);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_valid", rsp_valid, 1'b1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_valid", rsp_valid, 1'b0);
    chk("bp_after_grant", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset during EXEC: outputs clear at once, no response, pointer back to 0
    set_req(2, 2'b01, 8'h81, 8'h18);
    req_valid = 4'b0100;
    wait_grant(g);
    chk("mid_grant", g, 2);
    req_valid = '1;
    rst = 1'b1;
    #1;
    chk("mid_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rsp_data", rsp_data, 8'h00);
    chk("mid_rsp_id", rsp_id, 2'd0);
    chk("mid_req_ready", req_ready, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_no_rsp", rsp_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_grant(g);
    chk("mid_ptr_zero", g, 0);
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Wrap and skip: pointer at 3 with only requester 1 valid
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    wait_grant(g);
    chk("wrap_setup", g, 2);
    req_valid = 4'b0010;
    wait_grant(g);
    chk("wrap_grant1", g, 1);
    req_valid = 4'b0110;
    wait_grant(g);
    chk("wrap_ptr2", g, 2);
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    rand_phase();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
